// File: rtl/if_fetch_buffer.sv
// if_fetch_buffer: mips32 instruction-fetch stage with a small {pc, inst} FIFO towards decode.
//
// Owns the PC and drives the instruction ROM (chip enable + byte address),
// capturing each fetched {pc, inst} pair into a DEPTH-entry FIFO that feeds
// decode through a valid/ready handshake. A redirect from decode flushes the
// FIFO and reloads the PC with the word-aligned target.
//
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   rom_ce_o, rom_addr_o     ROM chip enable and byte address (= pc)
//   rom_data_i               combinational ROM read data
//   branch_flag_i            redirect request from decode
//   branch_target_i          redirect address (low two bits ignored)
//   id_ready_i               decode accepts the head entry
//   id_valid_o               head entry valid
//   id_pc_o, id_inst_o       head entry contents (0 when empty)
//
// Optional build macro FETCH_STATS_EN adds fetch_cnt_o, stall_cnt_o and
// flush_cnt_o free-running 32-bit event counters.
module if_fetch_buffer #(
    parameter int              PC_W     = 32,
    parameter int              INST_W   = 32,
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              rom_ce_o,
    output logic [PC_W-1:0]   rom_addr_o,
    input  logic [INST_W-1:0] rom_data_i,
    input  logic              branch_flag_i,
    input  logic [PC_W-1:0]   branch_target_i,
    input  logic              id_ready_i,
    output logic              id_valid_o,
    output logic [PC_W-1:0]   id_pc_o,
    output logic [INST_W-1:0] id_inst_o
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]       fetch_cnt_o,
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       flush_cnt_o
`endif
);
    localparam int         AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [PC_W-1:0]   pc;
    logic              run;
    logic [AW:0]       count;
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [PC_W-1:0]   pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];
    logic              pop;
    logic              fetch;

    // A full FIFO may still fetch when the head leaves in the same cycle.
    always_comb begin
        pop   = id_valid_o & id_ready_i & ~branch_flag_i;
        fetch = run & ~branch_flag_i & ((count != FULL) | pop);
    end

    assign rom_ce_o   = fetch;
    assign rom_addr_o = pc;
    assign id_valid_o = count != '0;
    assign id_pc_o    = id_valid_o ? pc_mem[rd_ptr] : '0;
    assign id_inst_o  = id_valid_o ? inst_mem[rd_ptr] : '0;

    // run holds fetch off for the first cycle after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc     <= RESET_PC;
            run    <= 1'b0;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (branch_flag_i) begin
            pc     <= {branch_target_i[PC_W-1:2], 2'b00};
            run    <= 1'b1;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            run    <= 1'b1;
            pc     <= fetch ? pc + PC_W'(4) : pc;
            wr_ptr <= fetch ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
            count  <= count + (AW+1)'(fetch) - (AW+1)'(pop);
        end
    end

    // Storage needs no reset: entries are only observed while counted valid.
    always_ff @(posedge clk) begin
        if (fetch) begin
            pc_mem[wr_ptr]   <= pc;
            inst_mem[wr_ptr] <= rom_data_i;
        end
    end

`ifdef FETCH_STATS_EN
    logic stall;
    assign stall = run & ~branch_flag_i & (count == FULL) & ~pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_o <= '0;
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            fetch_cnt_o <= fetch_cnt_o + 32'(fetch);
            stall_cnt_o <= stall_cnt_o + 32'(stall);
            flush_cnt_o <= flush_cnt_o + 32'(branch_flag_i);
        end
    end
`endif
endmodule

// File: tb/tb_if_fetch_buffer.sv
// tb_if_fetch_buffer: self-checking bench for if_fetch_buffer with a queue scoreboard.
module tb_if_fetch_buffer;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic        rom_ce_o;
    logic [31:0] rom_addr_o;
    logic [31:0] rom_data_i;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        id_ready_i;
    logic        id_valid_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
`ifdef FETCH_STATS_EN
    logic [31:0] fetch_cnt_o, stall_cnt_o, flush_cnt_o;
    int unsigned m_fetch, m_stall, m_flush;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] q[$];
    logic [31:0] m_pc;
    logic        m_run;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_of(input logic [31:0] a);
        return 32'h1000_0000 + {2'b00, a[31:2]};
    endfunction

    assign rom_data_i = rom_ce_o ? rom_of(rom_addr_o) : 32'h0;

    if_fetch_buffer #(.PC_W(32), .INST_W(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .rom_ce_o(rom_ce_o), .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i),
        .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
        .id_ready_i(id_ready_i), .id_valid_o(id_valid_o),
        .id_pc_o(id_pc_o), .id_inst_o(id_inst_o)
`ifdef FETCH_STATS_EN
        , .fetch_cnt_o(fetch_cnt_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
`endif
    );

    // Reference model: expected fetches are pushed as they are issued and
    // popped when decode takes the head entry.
    always @(posedge clk or posedge rst) begin : model
        bit p, f;
        if (rst) begin
            q.delete();
            m_pc  <= RESET_PC;
            m_run <= 1'b0;
`ifdef FETCH_STATS_EN
            m_fetch = 0; m_stall = 0; m_flush = 0;
`endif
        end else if (branch_flag_i) begin
            q.delete();
            m_pc  <= {branch_target_i[31:2], 2'b00};
            m_run <= 1'b1;
`ifdef FETCH_STATS_EN
            m_flush = m_flush + 1;
`endif
        end else begin
            p = q.size() != 0 && id_ready_i;
            f = m_run && (q.size() < DEPTH || p);
`ifdef FETCH_STATS_EN
            if (f) m_fetch = m_fetch + 1;
            if (m_run && q.size() == DEPTH && !p) m_stall = m_stall + 1;
`endif
            if (p) void'(q.pop_front());
            if (f) begin
                q.push_back(m_pc);
                m_pc <= m_pc + 32'd4;
            end
            m_run <= 1'b1;
        end
    end

    // Scoreboard compare of every observable output once per cycle.
    always @(negedge clk) begin : scoreboard
        logic        ev, ece;
        logic [31:0] epc, einst;
        ev    = q.size() != 0;
        epc   = ev ? q[0] : 32'h0;
        einst = ev ? rom_of(q[0]) : 32'h0;
        ece   = m_run && !branch_flag_i && (q.size() < DEPTH || (ev && id_ready_i));
        checks++;
        if ({rom_ce_o, rom_addr_o, id_valid_o, id_pc_o, id_inst_o} !== {ece, m_pc, ev, epc, einst}) begin
            errors++;
            $display("FAIL scoreboard @%0t: got ce=%b addr=%h v=%b pc=%h inst=%h, expected ce=%b addr=%h v=%b pc=%h inst=%h",
                     $time, rom_ce_o, rom_addr_o, id_valid_o, id_pc_o, id_inst_o, ece, m_pc, ev, epc, einst);
        end
`ifdef FETCH_STATS_EN
        checks++;
        if ({fetch_cnt_o, stall_cnt_o, flush_cnt_o} !== {m_fetch, m_stall, m_flush}) begin
            errors++;
            $display("FAIL stats_model: got %0d/%0d/%0d expected %0d/%0d/%0d",
                     fetch_cnt_o, stall_cnt_o, flush_cnt_o, m_fetch, m_stall, m_flush);
        end
`endif
    end

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if ({rom_ce_o, rom_addr_o, id_valid_o, id_pc_o, id_inst_o} !== {1'b0, RESET_PC, 1'b0, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL reset_state: got ce=%b addr=%h v=%b pc=%h inst=%h", rom_ce_o, rom_addr_o, id_valid_o, id_pc_o, id_inst_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_stream;
        id_ready_i = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (rom_ce_o !== 1'b0) begin errors++; $display("FAIL no_fetch_after_release: ce=%b expected 0", rom_ce_o); end
        @(negedge clk);
        checks++;
        if ({rom_ce_o, rom_addr_o, id_valid_o} !== {1'b1, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL first_fetch: got ce=%b addr=%h v=%b expected 1/00000000/0", rom_ce_o, rom_addr_o, id_valid_o);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if ({id_valid_o, id_pc_o, id_inst_o} !== {1'b1, 32'(4*k), 32'h1000_0000 + 32'(k)}) begin
                errors++;
                $display("FAIL stream_%0d: got v=%b pc=%h inst=%h expected pc=%h", k, id_valid_o, id_pc_o, id_inst_o, 32'(4*k));
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_full;
        rst = 1'b1;
        #1;
        @(posedge clk); #1;
        id_ready_i = 1'b0;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({rom_ce_o, rom_addr_o, id_valid_o, id_pc_o} !== {1'b0, 32'h10, 1'b1, 32'h0}) begin
            errors++;
            $display("FAIL full_stall: got ce=%b addr=%h v=%b pc=%h expected 0/00000010/1/00000000", rom_ce_o, rom_addr_o, id_valid_o, id_pc_o);
        end
        @(posedge clk); #1;
        id_ready_i = 1'b1;
        @(negedge clk);
        checks++;
        if ({rom_ce_o, rom_addr_o, id_pc_o} !== {1'b1, 32'h10, 32'h0}) begin
            errors++;
            $display("FAIL full_pop_fetch: got ce=%b addr=%h pc=%h expected 1/00000010/00000000", rom_ce_o, rom_addr_o, id_pc_o);
        end
        @(negedge clk);
        checks++;
        if (id_pc_o !== 32'h4) begin errors++; $display("FAIL drain_order: pc=%h expected 00000004", id_pc_o); end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_redirect;
        id_ready_i = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        branch_flag_i   = 1'b1;
        branch_target_i = 32'h0000_0102;
        id_ready_i      = 1'b1;
        @(negedge clk);
        checks++;
        if ({rom_ce_o, id_valid_o} !== 2'b01) begin
            errors++;
            $display("FAIL redirect_cycle: got ce=%b v=%b expected 0/1", rom_ce_o, id_valid_o);
        end
        @(posedge clk); #1;
        branch_flag_i = 1'b0;
        @(negedge clk);
        checks++;
        if ({id_valid_o, rom_addr_o, rom_ce_o} !== {1'b0, 32'h100, 1'b1}) begin
            errors++;
            $display("FAIL redirect_next: got v=%b addr=%h ce=%b expected 0/00000100/1", id_valid_o, rom_addr_o, rom_ce_o);
        end
        @(negedge clk);
        checks++;
        if ({id_pc_o, id_inst_o} !== {32'h100, 32'h1000_0040}) begin
            errors++;
            $display("FAIL redirect_head: got pc=%h inst=%h expected 00000100/10000040", id_pc_o, id_inst_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        branch_flag_i   = 1'b1;
        branch_target_i = 32'h200;
        @(posedge clk); #1;
        branch_target_i = 32'h300;
        @(negedge clk);
        checks++;
        if ({rom_ce_o, rom_addr_o} !== {1'b0, 32'h200}) begin
            errors++;
            $display("FAIL b2b_hold: got ce=%b addr=%h expected 0/00000200", rom_ce_o, rom_addr_o);
        end
        @(posedge clk); #1;
        branch_flag_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (id_pc_o !== 32'h300) begin errors++; $display("FAIL b2b_last_wins: pc=%h expected 00000300", id_pc_o); end
        @(posedge clk); #1;
    endtask

    task automatic test_wrap;
        branch_flag_i   = 1'b1;
        branch_target_i = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        branch_flag_i = 1'b0;
        @(negedge clk);
        checks++;
        if (rom_addr_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL align: addr=%h expected fffffffc", rom_addr_o); end
        @(negedge clk);
        checks++;
        if ({rom_addr_o, id_pc_o, id_inst_o} !== {32'h0, 32'hFFFF_FFFC, 32'h4FFF_FFFF}) begin
            errors++;
            $display("FAIL pc_wrap: got addr=%h pc=%h inst=%h expected 00000000/fffffffc/4fffffff", rom_addr_o, id_pc_o, id_inst_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        id_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({rom_ce_o, rom_addr_o, id_valid_o, id_pc_o, id_inst_o} !== {1'b0, RESET_PC, 1'b0, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL async_reset: got ce=%b addr=%h v=%b pc=%h inst=%h", rom_ce_o, rom_addr_o, id_valid_o, id_pc_o, id_inst_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({rom_ce_o, rom_addr_o} !== {1'b1, RESET_PC}) begin
            errors++;
            $display("FAIL refetch_reset_pc: got ce=%b addr=%h", rom_ce_o, rom_addr_o);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

`ifdef FETCH_STATS_EN
    task automatic test_stats;
        rst = 1'b1;
        #1;
        @(posedge clk); #1;
        id_ready_i = 1'b0;
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        branch_flag_i   = 1'b1;
        branch_target_i = 32'h0;
        @(posedge clk); #1;
        branch_flag_i = 1'b0;
        id_ready_i    = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({fetch_cnt_o, stall_cnt_o, flush_cnt_o} !== {32'd10, 32'd3, 32'd1}) begin
            errors++;
            $display("FAIL stats: got %0d/%0d/%0d expected 10/3/1", fetch_cnt_o, stall_cnt_o, flush_cnt_o);
        end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        id_ready_i = 1'b0;
        branch_flag_i = 1'b0;
        branch_target_i = 32'h0;
        #1 rst = 1'b1;
        test_reset();
        test_stream();
        test_full();
        test_redirect();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
`ifdef FETCH_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
